// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and datapath:
// FSM state encoding, opcode/funct constants and control-field codes.
package mips_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsAddu,
        ClsSubu,
        ClsOri,
        ClsLui,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsJ,
        ClsIllegal
    } instr_cls_e;

    // Opcodes (instr[31:26]) and R-type function codes (instr[5:0])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSubu  = 6'b100011;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluOr    = 2'b10;
    localparam logic [1:0] AluPassB = 2'b11;

    localparam logic [1:0] ExtZero  = 2'b00;
    localparam logic [1:0] ExtSign  = 2'b01;
    localparam logic [1:0] ExtUpper = 2'b10;

    localparam logic [1:0] NpcPc4    = 2'b00;
    localparam logic [1:0] NpcBranch = 2'b01;

    // Static per-instruction control fields produced by the decoder
    typedef struct packed {
        instr_cls_e cls;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [1:0] alu_ctr;
    } dec_t;

    // Register-writing ALU instructions that go EXEC -> WB directly
    function automatic logic is_alu_cls(instr_cls_e c);
        return (c == ClsAddu) || (c == ClsSubu) || (c == ClsOri) || (c == ClsLui);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface mips_mc_ctrl_if;
    logic [31:0] Instruction;
    logic        zero;
    logic        mem_ready;
    logic        halt_req;

    logic        RegDst;
    logic        RegWr;
    logic [1:0]  ExtOp;
    logic [1:0]  ALUctr;
    logic [1:0]  nPC_sel;
    logic        MemtoReg;
    logic        MemWr;
    logic        ALUSrc;
    logic        j_sel;
    logic        pc_wr;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_cnt;

    modport master (
        input  Instruction, zero, mem_ready, halt_req,
        output RegDst, RegWr, ExtOp, ALUctr, nPC_sel, MemtoReg, MemWr, ALUSrc, j_sel,
        output pc_wr, state, halted, illegal, instr_cnt
    );

    modport slave (
        output Instruction, zero, mem_ready, halt_req,
        input  RegDst, RegWr, ExtOp, ALUctr, nPC_sel, MemtoReg, MemWr, ALUSrc, j_sel,
        input  pc_wr, state, halted, illegal, instr_cnt
    );
endinterface

// File: rtl/mips_decode.sv
// Purely combinational opcode/funct decoder: instruction class plus the
// static control fields that stay constant for the whole instruction.
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Map opcode/funct to class and static fields; unknown encodings stay illegal
    always_comb begin
        dec            = '0;
        dec.cls        = ClsIllegal;
        case (op)
            OpRtype: begin
                if (funct == FnAddu) begin
                    dec.cls     = ClsAddu;
                    dec.reg_dst = 1'b1;
                    dec.alu_ctr = AluAdd;
                end else if (funct == FnSubu) begin
                    dec.cls     = ClsSubu;
                    dec.reg_dst = 1'b1;
                    dec.alu_ctr = AluSub;
                end
            end
            OpOri: begin
                dec.cls     = ClsOri;
                dec.alu_src = 1'b1;
                dec.ext_op  = ExtZero;
                dec.alu_ctr = AluOr;
            end
            OpLui: begin
                dec.cls     = ClsLui;
                dec.alu_src = 1'b1;
                dec.ext_op  = ExtUpper;
                dec.alu_ctr = AluPassB;
            end
            OpLw: begin
                dec.cls        = ClsLw;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.ext_op     = ExtSign;
                dec.alu_ctr    = AluAdd;
            end
            OpSw: begin
                dec.cls     = ClsSw;
                dec.alu_src = 1'b1;
                dec.ext_op  = ExtSign;
                dec.alu_ctr = AluAdd;
            end
            OpBeq: begin
                dec.cls     = ClsBeq;
                dec.ext_op  = ExtSign;
                dec.alu_ctr = AluSub;
            end
            OpJ: begin
                dec.cls = ClsJ;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS controller: FSM sequencing, PC-write strobe, retire
// counter, sticky illegal flag and halt parking between instructions.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mips_mc_ctrl_if.master bus
);

    state_e      state_q, state_d;
    logic [11:0] ir_q;
    logic [11:0] dec_in;
    dec_t        dec;
    logic [15:0] instr_cnt_q;
    logic        illegal_q;
    logic        in_instr;
    logic        reg_wr;
    logic        mem_wr;
    logic        pc_wr;
    logic [1:0]  npc_sel;
    logic        j_sel;
    logic        unused_instr;

    assign unused_instr = ^bus.Instruction[25:6];

    // Decode live in DECODE, then from the captured copy so fields stay stable
    assign dec_in = (state_q == StDecode) ? {bus.Instruction[31:26], bus.Instruction[5:0]} : ir_q;

    mips_decode u_decode (
        .op    (dec_in[11:6]),
        .funct (dec_in[5:0]),
        .dec   (dec)
    );

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  state_d = bus.halt_req ? StHalt : StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                if (is_alu_cls(dec.cls))                          state_d = StWb;
                else if (dec.cls == ClsLw || dec.cls == ClsSw)    state_d = StMem;
                else                                              state_d = StFetch;
            end
            StMem: begin
                if (bus.mem_ready) state_d = (dec.cls == ClsLw) ? StWb : StFetch;
            end
            StWb:   state_d = StFetch;
            StHalt: if (!bus.halt_req) state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    // Per-state strobes; all forced low while rst is asserted
    always_comb begin
        in_instr = 1'b0;
        reg_wr   = 1'b0;
        mem_wr   = 1'b0;
        pc_wr    = 1'b0;
        npc_sel  = NpcPc4;
        j_sel    = 1'b0;
        if (!rst) begin
            case (state_q)
                StDecode: in_instr = 1'b1;
                StExec: begin
                    in_instr = 1'b1;
                    pc_wr    = (dec.cls == ClsBeq) || (dec.cls == ClsJ) ||
                               (dec.cls == ClsIllegal);
                end
                StMem: begin
                    in_instr = 1'b1;
                    mem_wr   = (dec.cls == ClsSw);
                    pc_wr    = (dec.cls == ClsSw) && bus.mem_ready;
                end
                StWb: begin
                    in_instr = 1'b1;
                    reg_wr   = 1'b1;
                    pc_wr    = 1'b1;
                end
                default: ;
            endcase
            if (pc_wr) begin
                npc_sel = (dec.cls == ClsBeq && bus.zero) ? NpcBranch : NpcPc4;
                j_sel   = (dec.cls == ClsJ);
            end
        end
    end

    // State, captured instruction fields, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            ir_q        <= '0;
            instr_cnt_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                ir_q <= {bus.Instruction[31:26], bus.Instruction[5:0]};
            end
            if (pc_wr) begin
                instr_cnt_q <= instr_cnt_q + 16'd1;
            end
            if (state_q == StExec && dec.cls == ClsIllegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign bus.RegDst    = in_instr & dec.reg_dst;
    assign bus.MemtoReg  = in_instr & dec.mem_to_reg;
    assign bus.ALUSrc    = in_instr & dec.alu_src;
    assign bus.ExtOp     = in_instr ? dec.ext_op : 2'b00;
    assign bus.ALUctr    = in_instr ? dec.alu_ctr : 2'b00;
    assign bus.RegWr     = reg_wr;
    assign bus.MemWr     = mem_wr;
    assign bus.pc_wr     = pc_wr;
    assign bus.nPC_sel   = npc_sel;
    assign bus.j_sel     = j_sel;
    assign bus.state     = state_q;
    assign bus.halted    = !rst && (state_q == StHalt);
    assign bus.illegal   = illegal_q;
    assign bus.instr_cnt = instr_cnt_q;

endmodule
